// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one ZBT SRAM port among four pixel clients (NTSC capture, VGA display,
// LPF, projective-transform fetch). At most one requester is granted per cycle;
// the winning command is registered onto the SRAM bus, and reads are tracked
// through a tag pipeline so the returned data can be steered back to the
// issuing client with a one-hot valid strobe.
//
// Client index mapping (bit position in every per-client vector):
//    3 = NTSC, 2 = VGA, 1 = LPF, 0 = PTF
//
// Ports:
//    clock        in   system clock
//    reset        in   synchronous, active-high
//    i_req        in   [3:0]          request per client
//    i_wr         in   [3:0]          per-client write flag (1 = write, 0 = read)
//    i_addr       in   [4*ADDR_W-1:0] per-client address, client i at [i*ADDR_W +: ADDR_W]
//    i_wdata      in   [4*DATA_W-1:0] per-client write data, packed like i_addr
//    o_grant      out  [3:0]          one-hot grant, combinational, same cycle as request
//    o_rvalid     out  [3:0]          one-hot read-return strobe (registered)
//    o_rdata      out  [DATA_W-1:0]   read data, holds when o_rvalid is 0 (registered)
//    o_mem_addr   out  [ADDR_W-1:0]   registered SRAM address
//    o_mem_write  out  [DATA_W-1:0]   registered SRAM write data (0 on reads/idle)
//    o_mem_wr     out                 registered SRAM write enable
//    i_mem_read   in   [DATA_W-1:0]   SRAM read data, READ_LATENCY cycles after command
//
// Priority: NTSC > VGA > round-robin {LPF, PTF}.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//    When defined, LPF and PTF each own a saturating wait counter; a client
//    that has waited MAX_WAIT cycles is promoted above NTSC and VGA for one
//    grant. When undefined the counters do not exist.
// -----------------------------------------------------------------------------

module sram_port_arbiter #(
   parameter int unsigned ADDR_W       = 19,
   parameter int unsigned DATA_W       = 36,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_WAIT     = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            i_req,
   input  logic [3:0]            i_wr,
   input  logic [4*ADDR_W-1:0]   i_addr,
   input  logic [4*DATA_W-1:0]   i_wdata,
   output logic [3:0]            o_grant,
   output logic [3:0]            o_rvalid,
   output logic [DATA_W-1:0]     o_rdata,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [DATA_W-1:0]     o_mem_write,
   output logic                  o_mem_wr,
   input  logic [DATA_W-1:0]     i_mem_read
);

   localparam int unsigned N_CLIENTS = 4;
   localparam int unsigned ID_W      = 2;
   localparam int unsigned TAG_N     = READ_LATENCY + 1;

   // One in-flight read: valid flag plus the issuing client id.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   // Reject parameter values the tag pipeline and starvation counters cannot support.
   if (READ_LATENCY < 1 || READ_LATENCY > 6 || MAX_WAIT < 1) begin : g_param_check
      $error("sram_port_arbiter: READ_LATENCY must be 1..6 and MAX_WAIT >= 1");
   end

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   logic                r_rr_ptr;        // 0 favours LPF, 1 favours PTF
   logic [1:0]          w_promo;         // [1] = LPF promoted, [0] = PTF promoted
   logic [3:0]          w_grant;
   logic                w_any_grant;
   logic [ID_W-1:0]     w_win_id;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_wdata;
   logic                w_win_wr;

   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_write;
   logic                r_mem_wr;
   logic [3:0]          r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   tag_t                r_tag [TAG_N];

   // ------------------------------------------------------------------------
   // Starvation guard for the round-robin pair
   // ------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] r_wait [2];        // index 1 = LPF, 0 = PTF

   // Count cycles spent requesting without a grant; saturate at MAX_WAIT.
   always_ff @(posedge clock) begin : p_wait
      if (reset) begin
         r_wait[0] <= '0;
         r_wait[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!i_req[i] || w_grant[i]) begin
               r_wait[i] <= '0;
            end else if (r_wait[i] != WAIT_MAX) begin
               r_wait[i] <= r_wait[i] + WAIT_W'(1);
            end
         end
      end
   end

   // Promotion needs a live request; a counter at MAX_WAIT alone is stale
   // on the cycle the request drops.
   always_comb begin : p_promo
      w_promo    = 2'b00;
      w_promo[1] = i_req[1] && (r_wait[1] == WAIT_MAX);
      w_promo[0] = i_req[0] && (r_wait[0] == WAIT_MAX);
   end
`else
   assign w_promo = 2'b00;
`endif

   // ------------------------------------------------------------------------
   // Grant selection (combinational, same cycle as request)
   // ------------------------------------------------------------------------
   always_comb begin : p_grant
      w_grant = 4'b0000;
      if (reset) begin
         w_grant = 4'b0000;
      end else if (w_promo == 2'b11) begin
         w_grant = r_rr_ptr ? 4'b0001 : 4'b0010;
      end else if (w_promo[1]) begin
         w_grant = 4'b0010;
      end else if (w_promo[0]) begin
         w_grant = 4'b0001;
      end else if (i_req[3]) begin
         w_grant = 4'b1000;
      end else if (i_req[2]) begin
         w_grant = 4'b0100;
      end else if (i_req[1] && i_req[0]) begin
         w_grant = r_rr_ptr ? 4'b0001 : 4'b0010;
      end else if (i_req[1]) begin
         w_grant = 4'b0010;
      end else if (i_req[0]) begin
         w_grant = 4'b0001;
      end
   end

   assign o_grant     = w_grant;
   assign w_any_grant = |w_grant;

   // Steer the winner's command fields; grant is one-hot so at most one hit.
   always_comb begin : p_winner
      w_win_id    = '0;
      w_win_addr  = '0;
      w_win_wdata = '0;
      w_win_wr    = 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (w_grant[i]) begin
            w_win_id    = ID_W'(i);
            w_win_addr  = i_addr[i*ADDR_W +: ADDR_W];
            w_win_wdata = i_wdata[i*DATA_W +: DATA_W];
            w_win_wr    = i_wr[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin pointer: moves away from whichever of LPF/PTF just won
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin : p_rr
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (w_grant[1]) begin
         r_rr_ptr <= 1'b1;
      end else if (w_grant[0]) begin
         r_rr_ptr <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // SRAM command register; idle cycles drive an all-zero command
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin : p_cmd
      if (reset || !w_any_grant) begin
         r_mem_addr  <= '0;
         r_mem_write <= '0;
         r_mem_wr    <= 1'b0;
      end else begin
         r_mem_addr  <= w_win_addr;
         r_mem_write <= w_win_wr ? w_win_wdata : '0;
         r_mem_wr    <= w_win_wr;
      end
   end

   // ------------------------------------------------------------------------
   // Tag pipeline: entry 0 aligns with the command on the bus, the last entry
   // aligns with the matching data on i_mem_read.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin : p_tag
      if (reset) begin
         for (int k = 0; k < TAG_N; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_tag[0] <= '{valid: w_any_grant && !w_win_wr, id: w_win_id};
         for (int k = 1; k < TAG_N; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read return: capture data and strobe the issuing client
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin : p_ret
      if (reset) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= '0;
         if (r_tag[TAG_N-1].valid) begin
            r_rvalid[r_tag[TAG_N-1].id] <= 1'b1;
            r_rdata                     <= i_mem_read;
         end
      end
   end

   assign o_mem_addr  = r_mem_addr;
   assign o_mem_write = r_mem_write;
   assign o_mem_wr    = r_mem_wr;
   assign o_rvalid    = r_rvalid;
   assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model (priority rules, a queue of
// pending reads with due times, and a shadow memory). A simple SRAM model
// answers the DUT's bus with READ_LATENCY cycles of delay.
// -----------------------------------------------------------------------------

module tb_sram_port_arbiter;

   localparam int unsigned ADDR_W   = 19;
   localparam int unsigned DATA_W   = 36;
   localparam int unsigned L        = 2;
   localparam int unsigned MAX_WAIT = 15;

   logic                clock = 1'b0;
   logic                rst;
   logic [3:0]          req;
   logic [3:0]          wr;
   logic [ADDR_W-1:0]   c_addr  [4];
   logic [DATA_W-1:0]   c_wdata [4];
   logic [4*ADDR_W-1:0] addr_bus;
   logic [4*DATA_W-1:0] wdata_bus;

   logic [3:0]          grant;
   logic [3:0]          rvalid;
   logic [DATA_W-1:0]   rdata;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_write;
   logic                mem_wr;
   logic [DATA_W-1:0]   mem_read;

   always #5 clock = ~clock;

   always_comb begin
      addr_bus  = '0;
      wdata_bus = '0;
      for (int i = 0; i < 4; i++) begin
         addr_bus[i*ADDR_W +: ADDR_W]  = c_addr[i];
         wdata_bus[i*DATA_W +: DATA_W] = c_wdata[i];
      end
   end

   sram_port_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .READ_LATENCY (L),
      .MAX_WAIT     (MAX_WAIT)
   ) dut (
      .clock       (clock),
      .reset       (rst),
      .i_req       (req),
      .i_wr        (wr),
      .i_addr      (addr_bus),
      .i_wdata     (wdata_bus),
      .o_grant     (grant),
      .o_rvalid    (rvalid),
      .o_rdata     (rdata),
      .o_mem_addr  (mem_addr),
      .o_mem_write (mem_write),
      .o_mem_wr    (mem_wr),
      .i_mem_read  (mem_read)
   );

   // Background contents of never-written locations; 0x100 holds 0xABCDE.
   function automatic logic [DATA_W-1:0] init_val(input logic [8:0] a);
      return 36'hABCDE ^ DATA_W'(a ^ 9'h100);
   endfunction

   // ---------------- SRAM model ----------------
   bit   [DATA_W-1:0] sram_mem [512];
   bit                sram_wr  [512];
   logic [DATA_W-1:0] dl       [L];

   assign mem_read = dl[L-1];

   always @(posedge clock) begin
      if (mem_wr) begin
         sram_mem[mem_addr[8:0]] <= mem_write;
         sram_wr[mem_addr[8:0]]  <= 1'b1;
      end
      dl[0] <= mem_wr ? DATA_W'({$urandom(), $urandom()})
                      : (sram_wr[mem_addr[8:0]] ? sram_mem[mem_addr[8:0]] : init_val(mem_addr[8:0]));
      for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
   end

   // ---------------- reference model ----------------
   typedef struct {
      int                due;
      logic [3:0]        oh;
      logic [DATA_W-1:0] data;
   } pend_t;

   int                n_tests = 0;
   int                n_fail  = 0;
   int                edge_n  = 0;
   logic              m_rr;
   int                m_wait [2];
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_write;
   logic              e_wr;
   logic [3:0]        e_rv;
   logic [DATA_W-1:0] e_rd;
   bit   [DATA_W-1:0] exp_mem [512];
   bit                exp_wr  [512];
   pend_t             pend [$];
   int                last_g;
   logic [3:0]        cap_grant;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner index from the priority rules, -1 for none.
   function automatic int model_grant();
      bit p_lpf;
      bit p_ptf;
      p_lpf = 1'b0;
      p_ptf = 1'b0;
      if (rst) return -1;
`ifdef ARB_STARVE_GUARD_EN
      p_lpf = req[1] && (m_wait[1] == int'(MAX_WAIT));
      p_ptf = req[0] && (m_wait[0] == int'(MAX_WAIT));
`endif
      if (p_lpf && p_ptf) return m_rr ? 0 : 1;
      if (p_lpf) return 1;
      if (p_ptf) return 0;
      if (req[3]) return 3;
      if (req[2]) return 2;
      if (req[1] && req[0]) return m_rr ? 0 : 1;
      if (req[1]) return 1;
      if (req[0]) return 0;
      return -1;
   endfunction

   function automatic logic [DATA_W-1:0] exp_read(input logic [8:0] a);
      return exp_wr[a] ? exp_mem[a] : init_val(a);
   endfunction

   // One clock: check grant mid-cycle, advance the model at the edge, check registers.
   task automatic run_cycle();
      int         g;
      logic [3:0] eg;
      logic [8:0] ix;
      #1;
      g  = model_grant();
      eg = 4'b0000;
      if (g >= 0) eg[g] = 1'b1;
      cap_grant = grant;
      chk("grant", grant, eg);
      @(posedge clock);
      edge_n++;
      if (rst) begin
         e_addr  = '0;
         e_write = '0;
         e_wr    = 1'b0;
         e_rv    = '0;
         e_rd    = '0;
         m_rr    = 1'b0;
         m_wait[0] = 0;
         m_wait[1] = 0;
         pend.delete();
      end else begin
         e_rv = '0;
         if (pend.size() > 0 && pend[0].due == edge_n) begin
            e_rv = pend[0].oh;
            e_rd = pend[0].data;
            void'(pend.pop_front());
         end
         if (g >= 0) begin
            ix      = 9'(c_addr[g]);
            e_addr  = c_addr[g];
            e_wr    = wr[g];
            e_write = wr[g] ? c_wdata[g] : '0;
            if (wr[g]) begin
               exp_mem[ix] = c_wdata[g];
               exp_wr[ix]  = 1'b1;
            end else begin
               pend.push_back('{due: edge_n + int'(L) + 1, oh: eg, data: exp_read(ix)});
            end
            if (g == 1) m_rr = 1'b1;
            else if (g == 0) m_rr = 1'b0;
         end else begin
            e_addr  = '0;
            e_write = '0;
            e_wr    = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (!req[i] || g == i) m_wait[i] = 0;
            else if (m_wait[i] < int'(MAX_WAIT)) m_wait[i]++;
         end
      end
      #1;
      chk("mem_addr",  mem_addr,  e_addr);
      chk("mem_write", mem_write, e_write);
      chk("mem_wr",    mem_wr,    e_wr);
      chk("rvalid",    rvalid,    e_rv);
      chk("rdata",     rdata,     e_rd);
      last_g = g;
   endtask

   task automatic set_client(input int i, input bit r, input bit w,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req[i]     = r;
      wr[i]      = w;
      c_addr[i]  = a;
      c_wdata[i] = d;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) run_cycle();
      rst = 1'b0;
   endtask

   initial begin
      int k_grant;
      rst = 1'b1;
      req = '0;
      wr  = '0;
      for (int i = 0; i < 4; i++) begin
         c_addr[i]  = '0;
         c_wdata[i] = '0;
      end

      // Reset held 3 cycles with every client requesting.
      req = 4'hF;
      repeat (3) begin
         run_cycle();
         chk("rst_grant",    cap_grant, 4'b0000);
         chk("rst_mem_wr",   mem_wr,    1'b0);
         chk("rst_mem_addr", mem_addr,  '0);
         chk("rst_rvalid",   rvalid,    4'b0000);
      end
      rst = 1'b0;
      req = '0;
      run_cycle();

      // Simple VGA read of 0x00100.
      set_client(2, 1'b1, 1'b0, 19'h00100, '0);
      run_cycle();
      chk("rd_grant",    cap_grant, 4'b0100);
      chk("rd_mem_addr", mem_addr,  19'h00100);
      chk("rd_mem_wr",   mem_wr,    1'b0);
      req[2] = 1'b0;
      run_cycle();
      run_cycle();
      chk("rd_rvalid_early", rvalid, 4'b0000);
      run_cycle();
      chk("rd_rvalid", rvalid, 4'b0100);
      chk("rd_rdata",  rdata,  36'hABCDE);

      // NTSC write and VGA read of the same address in the same cycle.
      set_client(3, 1'b1, 1'b1, 19'h00020, 36'h123456789);
      set_client(2, 1'b1, 1'b0, 19'h00020, '0);
      run_cycle();
      chk("pri_first", cap_grant, 4'b1000);
      req[3] = 1'b0;
      run_cycle();
      chk("pri_second", cap_grant, 4'b0100);
      req[2] = 1'b0;
      run_cycle();
      run_cycle();
      chk("pri_rv_quiet", rvalid, 4'b0000);
      run_cycle();
      chk("pri_rvalid", rvalid, 4'b0100);
      chk("pri_rdata",  rdata,  36'h123456789);
      run_cycle();
      chk("pri_rv_once", rvalid, 4'b0000);

      // LPF and PTF requesting continuously alternate, LPF first.
      do_reset(1);
      set_client(1, 1'b1, 1'b1, 19'h00001, 36'h11);
      set_client(0, 1'b1, 1'b1, 19'h00002, 36'h22);
      for (int n = 0; n < 6; n++) begin
         run_cycle();
         chk("rr_grant", cap_grant, (n % 2 == 0) ? 4'b0010 : 4'b0001);
      end
      req = '0;

      // Reset one cycle after a read grant discards the read.
      set_client(2, 1'b1, 1'b0, 19'h00007, '0);
      run_cycle();
      chk("mf_grant", cap_grant, 4'b0100);
      req[2] = 1'b0;
      rst    = 1'b1;
      run_cycle();
      rst    = 1'b0;
      for (int n = 0; n < 5; n++) begin
         run_cycle();
         chk("mf_rvalid", rvalid, 4'b0000);
         chk("mf_rdata",  rdata,  '0);
      end

      // NTSC saturates the port while PTF waits.
      do_reset(1);
      set_client(3, 1'b1, 1'b1, 19'h00003, 36'h55);
      set_client(0, 1'b1, 1'b0, 19'h00004, '0);
      k_grant = 0;
      for (int n = 1; n <= 20; n++) begin
         run_cycle();
         if (k_grant == 0 && cap_grant[0]) k_grant = n;
      end
`ifdef ARB_STARVE_GUARD_EN
      chk("starve_ptf_cycle", k_grant, 16);
`else
      chk("starve_ptf_never", k_grant, 0);
`endif
      req = '0;
      repeat (L + 3) run_cycle();

      // Randomized traffic honouring the hold-until-grant handshake.
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] || last_g == i) begin
               if ($urandom_range(99) < 35)
                  set_client(i, 1'b1, 1'($urandom_range(1)), 19'($urandom_range(15)),
                             DATA_W'({$urandom(), $urandom()}));
               else
                  req[i] = 1'b0;
            end
         end
         rst = ($urandom_range(199) == 0);
         run_cycle();
      end
      rst = 1'b0;
      req = '0;
      repeat (L + 3) run_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one ZBT SRAM port among the four pixel clients: NTSC capture, VGA display, LPF, and projective-transform fetch. Each cycle it grants at most one requester and registers the winning command onto the SRAM bus. It tracks in-flight reads with a tag pipeline and returns read data to the issuing client with a one-hot valid. One instance sits between the client muxing and each `zbt_6111` port.

## Interface

**Parameters**
- `ADDR_W`, default 19: SRAM address width.
- `DATA_W`, default 36: SRAM data width.
- `READ_LATENCY`, default 2: cycles from a command on `mem_*` to valid `mem_read`. Legal range 1–6.
- `MAX_WAIT`, default 15: starvation threshold in cycles. Used only with `ARB_STARVE_GUARD_EN`.

**Ports**
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req` in 4: request per client. Bit 3 = NTSC, bit 2 = VGA, bit 1 = LPF, bit 0 = PTF.
- `wr` in 4: per-client write flag. 1 = write, 0 = read.
- `addr` in 4*ADDR_W: per-client address. Client i occupies `[i*ADDR_W +: ADDR_W]`.
- `wdata` in 4*DATA_W: per-client write data, packed the same way.
- `grant` out 4: one-hot, combinational, same cycle as the request.
- `rvalid` out 4: one-hot read-return strobe.
- `rdata` out DATA_W: read data. Holds its last value when `rvalid` is 0.
- `mem_addr` out ADDR_W: registered SRAM address.
- `mem_write` out DATA_W: registered SRAM write data.
- `mem_wr` out 1: registered write enable.
- `mem_read` in DATA_W: SRAM read data.

## Operation

**Grant priority**
- Order is NTSC > VGA > round-robin {LPF, PTF}.
- A single `rr_ptr` bit selects which of LPF/PTF wins when both request. 0 favours LPF.
- `rr_ptr` toggles only when LPF or PTF is granted. After the grant it points away from the winner.
- `grant` = 0 when `req` = 0.

**Command register**
- On each clock edge: if any grant, `mem_addr`/`mem_write`/`mem_wr` <= the winner's `addr`/`wdata`/`wr`.
- Otherwise all three go to 0. `mem_write` is 0 on reads.

**Tag pipeline**
- Shift register of READ_LATENCY+1 entries. Each entry is {valid, 2-bit client id}.
- Entry 0 loads {1, id} when the granted command is a read, otherwise {0, x}.
- When the last entry is valid: `rdata` <= `mem_read`, and `rvalid`[id] <= 1.
- Writes never produce `rvalid`.

**Handshake**
- A client holds `req`, `wr`, `addr`, `wdata` stable until it sees `grant`.
- The cycle after a grant, the client may present a new request or drop `req`.

**Reset**
- Clears `mem_addr`, `mem_write`, `mem_wr`, `rdata`, `rvalid` and all tag entries to 0. `rr_ptr` = 0.
- Reads in flight at reset are discarded and produce no `rvalid`. Clients must re-issue them.
- `grant` is forced to 0 while `reset` is high.

## Timing

- Request in cycle t with `grant` in cycle t: the command is on `mem_*` in cycle t+1.
- A read granted in cycle t gives `rvalid`/`rdata` in cycle t+READ_LATENCY+2. With the default, that is t+4.
- Throughput: one command per cycle. Back-to-back reads from different clients return in grant order, one per cycle.
- Same-cycle write and read to the same address: the write wins the grant. The read is served later and returns the written data.
- A client that loses arbitration waits with no bound unless `ARB_STARVE_GUARD_EN` is defined.

## Configuration

- Macro: `ARB_STARVE_GUARD_EN`.
- **Defined:**
  - LPF and PTF each get a `$clog2(MAX_WAIT+1)`-bit wait counter.
  - The counter increments each cycle its `req` is high without `grant`, saturating at MAX_WAIT.
  - It clears on grant or when `req` is low.
  - A client whose counter equals MAX_WAIT is promoted above NTSC and VGA for one grant.
  - If both are promoted, `rr_ptr` picks the winner.
- **Not defined:** counters are absent and priority is strictly as listed under Operation.

## Test plan

- **Reset:** hold `reset` 3 cycles with all `req`=1 → `grant`=0, `mem_wr`=0, `mem_addr`=0, `rvalid`=0 throughout and on the first cycle after release.
- **Simple read:** VGA read of addr 0x00100 in cycle 5 with `mem_read` modelled to return 0xABCDE → `grant`=0100 in cycle 5, `mem_addr`=0x00100 with `mem_wr`=0 in cycle 6, `rvalid`=0100 with `rdata`=0xABCDE in cycle 9.
- **Priority:** NTSC write and VGA read request together → NTSC granted first, VGA the next cycle, exactly one `rvalid` (VGA) 4 cycles after its grant.
- **Round-robin:** LPF and PTF request continuously for 6 cycles → grants alternate LPF, PTF, LPF, PTF, LPF, PTF.
- **Reset mid-flight:** assert `reset` one cycle after a read grant → no `rvalid` for that read; `rdata`=0.
- **Starvation guard:** with `ARB_STARVE_GUARD_EN` defined and MAX_WAIT=15, NTSC requests every cycle while PTF requests → PTF granted on its 16th waiting cycle. Without the macro, PTF is never granted.
